// File: rtl/crf_tree_stage_pkg.sv
// Shared constants and elaboration-time helpers for the CRF tree-level datapath.
package crf_tree_stage_pkg;

  localparam int DEF_FEAT_W = 32;
  localparam int DEF_N_FEAT = 8;

  function automatic int crf_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Feature-index width; a single-feature sample still needs one index bit.
  function automatic int crf_fiw(input int n_feat);
    return (n_feat <= 2) ? 1 : crf_clog2(n_feat);
  endfunction

  // Node-index width; the root level has one node but keeps a 1-bit index.
  function automatic int crf_nw(input int stage);
    return (stage == 0) ? 1 : stage;
  endfunction

endpackage

// File: rtl/crf_feature_sel.sv
// N_FEAT:1 feature multiplexer; an index past the last feature yields zero.
module crf_feature_sel
  import crf_tree_stage_pkg::*;
#(
  parameter int FEAT_W = DEF_FEAT_W,
  parameter int N_FEAT = DEF_N_FEAT,
  parameter int FIW    = crf_fiw(N_FEAT)
) (
  input  logic [N_FEAT*FEAT_W-1:0] sample_i,
  input  logic [FIW-1:0]           fidx_i,
  output logic [FEAT_W-1:0]        feature_o
);

  always_comb begin
    feature_o = '0;
    for (int i = 0; i < N_FEAT; i++) begin
      if (fidx_i == FIW'(i)) feature_o = sample_i[i*FEAT_W +: FEAT_W];
    end
  end

endmodule

// File: rtl/crf_tree_stage.sv
// One Compact Random Forest tree level: node table, feature select and either a
// threshold split or an affine leaf, behind a 2-deep valid/ready pipeline.
module crf_tree_stage
  import crf_tree_stage_pkg::*;
#(
  parameter int  STAGE  = 1,
  parameter int  FEAT_W = DEF_FEAT_W,
  parameter int  N_FEAT = DEF_N_FEAT,
  parameter bit  LEAF   = 1'b0,
  localparam int NW     = crf_nw(STAGE),
  localparam int FIW    = crf_fiw(N_FEAT),
  localparam int SW     = N_FEAT * FEAT_W,
  localparam int RW     = 2 * FEAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [NW-1:0]     cfg_addr,
  input  logic [FIW-1:0]    cfg_fidx,
  input  logic [FEAT_W-1:0] cfg_a,
  input  logic [FEAT_W-1:0] cfg_b,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NW-1:0]     in_node,
  input  logic [SW-1:0]     in_sample,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NW:0]       out_node,
  output logic [SW-1:0]     out_sample,
  output logic [RW-1:0]     out_result
);

  localparam int TD = 1 << NW;

  function automatic logic [RW-1:0] affine(input logic [FEAT_W-1:0] a,
                                           input logic [FEAT_W-1:0] f,
                                           input logic [FEAT_W-1:0] b);
    logic [RW-1:0] prod;
    prod = RW'(a) * RW'(f);
    return prod + RW'(b);
  endfunction

  logic [FIW-1:0]    tbl_fidx_q [TD];
  logic [FEAT_W-1:0] tbl_a_q    [TD];
  logic [FEAT_W-1:0] tbl_b_q    [TD];
  logic [NW-1:0]     wr_idx;
  logic [NW-1:0]     rd_idx;

  logic              vld_p1_q;
  logic [NW-1:0]     node_p1_q;
  logic [SW-1:0]     sample_p1_q;
  logic [FIW-1:0]    fidx_p1_q;
  logic [FEAT_W-1:0] a_p1_q;
  logic [FEAT_W-1:0] b_p1_q;
  logic [FEAT_W-1:0] feature_p1;

  logic              go_right_d;
  logic [NW:0]       node_d;
  logic [RW-1:0]     result_d;

  logic              vld_p2_q;
  logic [NW:0]       node_p2_q;
  logic [SW-1:0]     sample_p2_q;
  logic [RW-1:0]     result_p2_q;

  logic              s1_adv;
  logic              s2_adv;

  // The root level has a single entry, so its index is pinned to zero.
  assign wr_idx = (STAGE == 0) ? '0 : cfg_addr;
  assign rd_idx = (STAGE == 0) ? '0 : in_node;

  assign s2_adv   = !vld_p2_q || out_ready;
  assign s1_adv   = !vld_p1_q || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TD; i++) begin
        tbl_fidx_q[i] <= '0;
        tbl_a_q[i]    <= '0;
        tbl_b_q[i]    <= '0;
      end
    end else if (cfg_we) begin
      tbl_fidx_q[wr_idx] <= cfg_fidx;
      tbl_a_q[wr_idx]    <= cfg_a;
      tbl_b_q[wr_idx]    <= cfg_b;
    end
  end

  // Stage 1: capture sample, node and the entry as it stood before this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      node_p1_q   <= '0;
      sample_p1_q <= '0;
      fidx_p1_q   <= '0;
      a_p1_q      <= '0;
      b_p1_q      <= '0;
    end else if (s1_adv) begin
      vld_p1_q <= in_valid;
      if (in_valid) begin
        node_p1_q   <= rd_idx;
        sample_p1_q <= in_sample;
        fidx_p1_q   <= tbl_fidx_q[rd_idx];
        a_p1_q      <= tbl_a_q[rd_idx];
        b_p1_q      <= tbl_b_q[rd_idx];
      end
    end
  end

  crf_feature_sel #(
    .FEAT_W (FEAT_W),
    .N_FEAT (N_FEAT),
    .FIW    (FIW)
  ) u_feature_sel (
    .sample_i  (sample_p1_q),
    .fidx_i    (fidx_p1_q),
    .feature_o (feature_p1)
  );

  always_comb begin
    go_right_d = feature_p1 < a_p1_q;
    node_d     = LEAF ? {1'b0, node_p1_q} : {node_p1_q, go_right_d};
    result_d   = LEAF ? affine(a_p1_q, feature_p1, b_p1_q) : '0;
  end

  // Stage 2: register the decision or leaf value; this is the output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2_q    <= 1'b0;
      node_p2_q   <= '0;
      sample_p2_q <= '0;
      result_p2_q <= '0;
    end else if (s2_adv) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        node_p2_q   <= node_d;
        sample_p2_q <= sample_p1_q;
        result_p2_q <= result_d;
      end
    end
  end

  assign out_valid  = vld_p2_q;
  assign out_node   = node_p2_q;
  assign out_sample = sample_p2_q;
  assign out_result = result_p2_q;

endmodule
